// File: rtl/jtag_pkg.sv
// Shared definitions for the boundary-scan chain: default geometry, chain length and cell kinds.
package jtag_pkg;

  localparam int DEF_NUM_IN  = 4;
  localparam int DEF_NUM_OUT = 4;

  typedef enum logic {
    CELL_IN,
    CELL_OUT
  } cell_kind_e;

  function automatic int bsr_len(input int nin, input int nout);
    return nin + nout;
  endfunction

  // Low indices sit next to TDO and belong to the input (pad -> core) cells.
  function automatic cell_kind_e cell_kind(input int idx, input int nin);
    return (idx < nin) ? CELL_IN : CELL_OUT;
  endfunction

endpackage

// File: rtl/jtag_bsr_cell.sv
// One boundary-scan cell: capture/shift flop, update flop and the test/functional output mux.
module jtag_bsr_cell #(
  parameter logic SAFE_BIT = 1'b0
) (
  input  logic tck,
  input  logic reset,
  input  logic i_capture,
  input  logic i_shift,
  input  logic i_update,
  input  logic i_mode,
  input  logic i_par,
  input  logic i_scan_in,
  output logic o_scan_out,
  output logic o_out
);

  logic r_shift;
  logic r_upd;

  always_ff @(posedge tck) begin
    if (reset) begin
      r_shift <= 1'b0;
      r_upd   <= SAFE_BIT;
    end else begin
      if (i_capture) begin
        r_shift <= i_par;
      end else if (i_shift) begin
        r_shift <= i_scan_in;
      end
      // Update samples the pre-edge shift value regardless of capture/shift this edge.
      if (i_update) begin
        r_upd <= r_shift;
      end
    end
  end

  assign o_scan_out = r_shift;
  assign o_out      = i_mode ? r_upd : i_par;

endmodule

// File: rtl/jtag_bsr_chain.sv
// Boundary-scan register chain between core and pads; input cells occupy the TDO end of the chain.
module jtag_bsr_chain
  import jtag_pkg::*;
#(
  parameter int                           NUM_IN   = DEF_NUM_IN,
  parameter int                           NUM_OUT  = DEF_NUM_OUT,
  parameter logic [NUM_IN+NUM_OUT-1:0]    SAFE_VAL = '0
) (
  input  logic               tck,
  input  logic               reset,
  input  logic               bsr_tdi,
  output logic               bsr_tdo,
  input  logic               bsr_capture,
  input  logic               bsr_shift,
  input  logic               bsr_update,
  input  logic               bsr_mode,
  input  logic [NUM_IN-1:0]  pad_in,
  output logic [NUM_IN-1:0]  core_in,
  input  logic [NUM_OUT-1:0] core_out,
  output logic [NUM_OUT-1:0] pad_out
);

  localparam int L = bsr_len(NUM_IN, NUM_OUT);

  // w_scan[gi+1] feeds cell gi; TDI enters at the top, TDO leaves from cell 0.
  logic [L:0]   w_scan;
  logic [L-1:0] w_out;

  assign w_scan[L] = bsr_tdi;
  assign bsr_tdo   = w_scan[0];

  for (genvar gi = 0; gi < L; gi++) begin : g_cell
    logic w_par;

    if (cell_kind(gi, NUM_IN) == CELL_IN) begin : g_in
      assign w_par = pad_in[gi];
    end else begin : g_out
      assign w_par = core_out[gi-NUM_IN];
    end

    jtag_bsr_cell #(
      .SAFE_BIT (SAFE_VAL[gi])
    ) u_cell (
      .tck        (tck),
      .reset      (reset),
      .i_capture  (bsr_capture),
      .i_shift    (bsr_shift),
      .i_update   (bsr_update),
      .i_mode     (bsr_mode),
      .i_par      (w_par),
      .i_scan_in  (w_scan[gi+1]),
      .o_scan_out (w_scan[gi]),
      .o_out      (w_out[gi])
    );
  end

  assign core_in = w_out[NUM_IN-1:0];
  assign pad_out = w_out[L-1:NUM_IN];

endmodule

// File: tb/tb_jtag_bsr_chain.sv
// Directed bench for jtag_bsr_chain with a queue-based reference model checked every cycle.
module tb_jtag_bsr_chain;

  logic       tck = 1'b0;
  logic       reset = 1'b0;
  logic       bsr_tdi = 1'b0;
  logic       bsr_tdo;
  logic       bsr_capture = 1'b0;
  logic       bsr_shift = 1'b0;
  logic       bsr_update = 1'b0;
  logic       bsr_mode = 1'b0;
  logic [3:0] pad_in = 4'h0;
  logic [3:0] core_in;
  logic [3:0] core_out = 4'h0;
  logic [3:0] pad_out;

  int n_chk  = 0;
  int n_fail = 0;

  jtag_bsr_chain #(
    .NUM_IN   (4),
    .NUM_OUT  (4),
    .SAFE_VAL (8'h00)
  ) dut (
    .tck         (tck),
    .reset       (reset),
    .bsr_tdi     (bsr_tdi),
    .bsr_tdo     (bsr_tdo),
    .bsr_capture (bsr_capture),
    .bsr_shift   (bsr_shift),
    .bsr_update  (bsr_update),
    .bsr_mode    (bsr_mode),
    .pad_in      (pad_in),
    .core_in     (core_in),
    .core_out    (core_out),
    .pad_out     (pad_out)
  );

  always #5 tck = ~tck;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the chain as a queue (front = TDO end), update stage as a word.
  bit         m_sh[$];
  logic [7:0] m_upd;
  bit         m_valid = 1'b0;

  initial begin
    forever begin
      @(posedge tck);
      if (reset) begin
        m_sh.delete();
        for (int i = 0; i < 8; i++) m_sh.push_back(1'b0);
        m_upd   = 8'h00;
        m_valid = 1'b1;
      end else if (m_valid) begin
        if (bsr_update)
          for (int i = 0; i < 8; i++) m_upd[i] = m_sh[i];
        if (bsr_capture) begin
          for (int i = 0; i < 4; i++) m_sh[i]   = pad_in[i];
          for (int i = 0; i < 4; i++) m_sh[i+4] = core_out[i];
        end else if (bsr_shift) begin
          void'(m_sh.pop_front());
          m_sh.push_back(bsr_tdi);
        end
      end
    end
  end

  always @(negedge tck) begin
    if (m_valid) begin
      chk("model_tdo", {7'b0, bsr_tdo}, {7'b0, m_sh[0]});
      chk("model_pad_out", {4'b0, pad_out}, {4'b0, (bsr_mode ? m_upd[7:4] : core_out)});
      chk("model_core_in", {4'b0, core_in}, {4'b0, (bsr_mode ? m_upd[3:0] : pad_in)});
    end
  end

  task automatic edge1();
    @(posedge tck);
    #1;
  endtask

  logic [7:0] got;
  logic [7:0] pat;

  initial begin
    // 1: reset with test mode on, then functional pass-through
    reset = 1'b1; bsr_mode = 1'b1; core_out = 4'hF;
    edge1();
    reset = 1'b0;
    chk("rst_tdo", {7'b0, bsr_tdo}, 8'h00);
    chk("rst_pad_out", {4'b0, pad_out}, 8'h00);
    chk("rst_core_in", {4'b0, core_in}, 8'h00);
    bsr_mode = 1'b0;
    #1;
    chk("rst_passthru", {4'b0, pad_out}, 8'h0F);

    // 2: capture then shift out 8'h5A LSB first
    pad_in = 4'hA; core_out = 4'h5; bsr_capture = 1'b1;
    edge1();
    bsr_capture = 1'b0; bsr_shift = 1'b1;
    got[0] = bsr_tdo;
    for (int k = 1; k < 8; k++) begin
      edge1();
      got[k] = bsr_tdo;
    end
    bsr_shift = 1'b0;
    chk("capture_shift_out", got, 8'h5A);

    // 3: shift in 8'hC3, update, test mode
    pat = 8'hC3;
    bsr_shift = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bsr_tdi = pat[k];
      edge1();
    end
    bsr_shift = 1'b0; bsr_update = 1'b1;
    edge1();
    bsr_update = 1'b0; bsr_mode = 1'b1;
    #1;
    chk("upd_pad_out", {4'b0, pad_out}, 8'h0C);
    chk("upd_core_in", {4'b0, core_in}, 8'h03);
    bsr_mode = 1'b0;
    #1;
    chk("func_pad_out", {4'b0, pad_out}, 8'h05);
    chk("func_core_in", {4'b0, core_in}, 8'h0A);

    // 4: shifting ones leaves test-mode outputs untouched until update
    bsr_mode = 1'b1; bsr_tdi = 1'b1; bsr_shift = 1'b1;
    for (int k = 0; k < 8; k++) begin
      edge1();
      chk("hold_pad_out", {4'b0, pad_out}, 8'h0C);
    end
    bsr_shift = 1'b0; bsr_update = 1'b1;
    edge1();
    bsr_update = 1'b0;
    chk("ones_pad_out", {4'b0, pad_out}, 8'h0F);
    chk("ones_core_in", {4'b0, core_in}, 8'h0F);

    // 5: capture beats shift; update samples the pre-shift value
    pad_in = 4'h6; core_out = 4'h9; bsr_tdi = 1'b1;
    bsr_capture = 1'b1; bsr_shift = 1'b1;
    edge1();
    bsr_capture = 1'b0;
    chk("cap_wins_tdo", {7'b0, bsr_tdo}, 8'h00);
    bsr_update = 1'b1;
    edge1();
    bsr_update = 1'b0; bsr_shift = 1'b0;
    chk("upd_pre_shift_pad", {4'b0, pad_out}, 8'h09);
    chk("upd_pre_shift_core", {4'b0, core_in}, 8'h06);
    chk("shift_after_cap_tdo", {7'b0, bsr_tdo}, 8'h01);

    // 6: reset mid-shift discards partial data and restores safe outputs
    bsr_tdi = 1'b1; bsr_shift = 1'b1;
    for (int k = 0; k < 3; k++) edge1();
    reset = 1'b1;
    edge1();
    reset = 1'b0;
    chk("midrst_tdo", {7'b0, bsr_tdo}, 8'h00);
    chk("midrst_pad_out", {4'b0, pad_out}, 8'h00);
    chk("midrst_core_in", {4'b0, core_in}, 8'h00);
    bsr_tdi = 1'b0;
    for (int k = 0; k < 8; k++) begin
      edge1();
      chk("midrst_flush_tdo", {7'b0, bsr_tdo}, 8'h00);
    end
    bsr_shift = 1'b0;
    edge1();
    edge1();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
